// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared writeback stage types and constants
package writeback_stage_pkg;

  // Writeback FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    COMMIT    = 2'd2
  } wb_state_t;

  // Register index that aliases the program counter
  localparam logic [3:0] WB_PC_REG = 4'd15;

  // Default datapath width of the CPU
  localparam int WB_WIDTH = 32;

endpackage

// File: rtl/mux2to1.sv
// rtl/mux2to1.sv - generic two-input multiplexer
module mux2to1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  // Select d1 when s is high, otherwise d0
  assign y = s ? d1 : d0;

endmodule

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - load-response wait counter with expiry flag
module wb_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Count wait cycles; hold at the last value so expiry stays asserted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expiry is reached on the final permitted wait cycle
  assign expired = (cnt == LAST);

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register and register-file write port driver
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int         WIDTH   = WB_WIDTH,
  parameter int         TIMEOUT = 64,
  parameter logic [3:0] PC_REG  = WB_PC_REG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_m,
  output logic             ready_m,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [3:0]       WA3M,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic             rdata_valid,
  input  logic [WIDTH-1:0] rdata,
  output logic             RegWriteW,
  output logic [3:0]       WA3W,
  output logic [WIDTH-1:0] ResultW,
  output logic             PCSrcW,
  output logic             load_err
);

  wb_state_t        state;
  logic             rw_q;
  logic [3:0]       wa3_q;
  logic             waiting;
  logic             accept;
  logic             expired;
  logic [WIDTH-1:0] result_sel;

  assign waiting = (state == WAIT_LOAD);
  assign ready_m = !waiting;
  assign accept  = valid_m && ready_m;

  // While waiting the only data source is the load response; otherwise the ALU result
  mux2to1 #(.WIDTH(WIDTH)) u_result_mux (
    .d0 (ALUOutM),
    .d1 (rdata),
    .s  (waiting),
    .y  (result_sel)
  );

  wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!waiting),
    .enable  (waiting),
    .expired (expired)
  );

  // Writeback FSM with registered write-port outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rw_q      <= 1'b0;
      wa3_q     <= '0;
      RegWriteW <= 1'b0;
      WA3W      <= '0;
      ResultW   <= '0;
      PCSrcW    <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      RegWriteW <= 1'b0;
      PCSrcW    <= 1'b0;
      case (state)
        WAIT_LOAD: begin
          // A response on the expiry edge still commits
          if (rdata_valid) begin
            RegWriteW <= rw_q;
            WA3W      <= wa3_q;
            ResultW   <= result_sel;
            PCSrcW    <= rw_q && (wa3_q == PC_REG);
            state     <= COMMIT;
          end else if (expired) begin
            load_err <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          if (rdata_valid) begin
            load_err <= 1'b1;
          end
          if (accept) begin
            rw_q  <= RegWriteM;
            wa3_q <= WA3M;
            if (MemtoRegM && RegWriteM) begin
              state <= WAIT_LOAD;
            end else begin
              RegWriteW <= RegWriteM;
              WA3W      <= WA3M;
              ResultW   <= result_sel;
              PCSrcW    <= RegWriteM && (WA3M == PC_REG);
              state     <= COMMIT;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed vector bench for writeback_stage
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        valid_m;
  logic        ready_m;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic [3:0]  WA3M;
  logic [31:0] ALUOutM;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        RegWriteW;
  logic [3:0]  WA3W;
  logic [31:0] ResultW;
  logic        PCSrcW;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  writeback_stage #(.WIDTH(32), .TIMEOUT(64), .PC_REG(4'd15)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_m     (valid_m),
    .ready_m     (ready_m),
    .RegWriteM   (RegWriteM),
    .MemtoRegM   (MemtoRegM),
    .WA3M        (WA3M),
    .ALUOutM     (ALUOutM),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .RegWriteW   (RegWriteW),
    .WA3W        (WA3W),
    .ResultW     (ResultW),
    .PCSrcW      (PCSrcW),
    .load_err    (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        rw;
    logic        m2r;
    logic [3:0]  wa3;
    logic [31:0] alu;
    logic        rdv;
    logic [31:0] rd;
    logic        e_rw;
    logic [3:0]  e_wa3;
    logic [31:0] e_res;
    logic        e_pc;
    logic        e_rdy;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [3:0] wa3,
                       input logic [31:0] alu, input logic rdv, input logic [31:0] rd);
    valid_m     = v;
    RegWriteM   = rw;
    MemtoRegM   = m2r;
    WA3M        = wa3;
    ALUOutM     = alu;
    rdata_valid = rdv;
    rdata       = rd;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic rw, input logic m2r, input logic [3:0] wa3,
                     input logic [31:0] alu, input logic rdv, input logic [31:0] rd,
                     input logic e_rw, input logic [3:0] e_wa3, input logic [31:0] e_res,
                     input logic e_pc, input logic e_rdy, input logic e_err);
    vec_t r;
    r.v = v; r.rw = rw; r.m2r = m2r; r.wa3 = wa3; r.alu = alu; r.rdv = rdv; r.rd = rd;
    r.e_rw = e_rw; r.e_wa3 = e_wa3; r.e_res = e_res; r.e_pc = e_pc; r.e_rdy = e_rdy; r.e_err = e_err;
    vecs.push_back(r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int pulses;

  initial begin
    reset = 1'b0;
    idle_in();
    #1;
    chk("reset.ready_m", 32'(ready_m), 32'd1);
    chk("reset.RegWriteW", 32'(RegWriteW), 32'd0);
    chk("reset.WA3W", 32'(WA3W), 32'd0);
    chk("reset.ResultW", ResultW, 32'd0);
    chk("reset.PCSrcW", 32'(PCSrcW), 32'd0);
    chk("reset.load_err", 32'(load_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    //   v  rw m2r wa3    alu            rdv rd             e_rw e_wa3  e_res         pc rdy err
    add(1, 1, 0, 4'd3,  32'h12345678, 0, 32'h0,        1, 4'd3,  32'h12345678, 0, 1, 0);
    add(0, 0, 0, 4'd0,  32'h0,        0, 32'h0,        0, 4'd3,  32'h12345678, 0, 1, 0);
    add(1, 1, 1, 4'd5,  32'h0000DEAD, 0, 32'h0,        0, 4'd3,  32'h12345678, 0, 0, 0);
    add(0, 0, 0, 4'd0,  32'h0,        0, 32'h0,        0, 4'd3,  32'h12345678, 0, 0, 0);
    add(0, 0, 0, 4'd0,  32'h0,        0, 32'h0,        0, 4'd3,  32'h12345678, 0, 0, 0);
    add(0, 0, 0, 4'd0,  32'h0,        1, 32'hCAFEF00D, 1, 4'd5,  32'hCAFEF00D, 0, 1, 0);
    add(0, 0, 0, 4'd0,  32'h0,        0, 32'h0,        0, 4'd5,  32'hCAFEF00D, 0, 1, 0);
    add(1, 1, 0, 4'd1,  32'h11,       0, 32'h0,        1, 4'd1,  32'h11,       0, 1, 0);
    add(1, 1, 0, 4'd2,  32'h22,       0, 32'h0,        1, 4'd2,  32'h22,       0, 1, 0);
    add(1, 1, 0, 4'd3,  32'h33,       0, 32'h0,        1, 4'd3,  32'h33,       0, 1, 0);
    add(1, 1, 0, 4'd4,  32'h44,       0, 32'h0,        1, 4'd4,  32'h44,       0, 1, 0);
    add(0, 0, 0, 4'd0,  32'h0,        0, 32'h0,        0, 4'd4,  32'h44,       0, 1, 0);
    add(1, 1, 0, 4'd15, 32'h100,      0, 32'h0,        1, 4'd15, 32'h100,      1, 1, 0);
    add(0, 0, 0, 4'd0,  32'h0,        0, 32'h0,        0, 4'd15, 32'h100,      0, 1, 0);
    add(1, 0, 1, 4'd15, 32'h77,       0, 32'h0,        0, 4'd15, 32'h77,       0, 1, 0);
    add(0, 0, 0, 4'd0,  32'h0,        0, 32'h0,        0, 4'd15, 32'h77,       0, 1, 0);
    add(1, 1, 1, 4'd2,  32'h0,        0, 32'h0,        0, 4'd15, 32'h77,       0, 0, 0);
    add(1, 1, 0, 4'd6,  32'h66,       1, 32'hA5A5A5A5, 1, 4'd2,  32'hA5A5A5A5, 0, 1, 0);
    add(1, 1, 0, 4'd9,  32'h99,       0, 32'h0,        1, 4'd9,  32'h99,       0, 1, 0);
    add(0, 0, 0, 4'd0,  32'h0,        0, 32'h0,        0, 4'd9,  32'h99,       0, 1, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].wa3, vecs[i].alu, vecs[i].rdv, vecs[i].rd);
      step();
      chk($sformatf("vec%0d.RegWriteW", i), 32'(RegWriteW), 32'(vecs[i].e_rw));
      chk($sformatf("vec%0d.WA3W", i), 32'(WA3W), 32'(vecs[i].e_wa3));
      chk($sformatf("vec%0d.ResultW", i), ResultW, vecs[i].e_res);
      chk($sformatf("vec%0d.PCSrcW", i), 32'(PCSrcW), 32'(vecs[i].e_pc));
      chk($sformatf("vec%0d.ready_m", i), 32'(ready_m), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d.load_err", i), 32'(load_err), 32'(vecs[i].e_err));
    end

    // Asynchronous reset in the middle of a load wait
    drive(1'b1, 1'b1, 1'b1, 4'd12, 32'h0, 1'b0, 32'h0);
    step();
    idle_in();
    step();
    step();
    chk("rstwait.ready_before", 32'(ready_m), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("rstwait.RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rstwait.WA3W", 32'(WA3W), 32'd0);
    chk("rstwait.ResultW", ResultW, 32'd0);
    chk("rstwait.PCSrcW", 32'(PCSrcW), 32'd0);
    chk("rstwait.ready_m", 32'(ready_m), 32'd1);
    chk("rstwait.load_err", 32'(load_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h5555AAAA);
    step();
    chk("late_rsp.RegWriteW", 32'(RegWriteW), 32'd0);
    chk("late_rsp.ResultW", ResultW, 32'd0);
    chk("late_rsp.load_err", 32'(load_err), 32'd1);
    idle_in();
    step();
    chk("late_rsp.err_sticky", 32'(load_err), 32'd1);

    // Timeout: no response for the whole window
    do_reset();
    chk("timeout.err_cleared", 32'(load_err), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 4'd6, 32'h0, 1'b0, 32'h0);
    step();
    idle_in();
    pulses = 0;
    for (int k = 1; k <= 63; k++) begin
      step();
      if (RegWriteW) pulses++;
    end
    chk("timeout.ready_at_63", 32'(ready_m), 32'd0);
    chk("timeout.err_at_63", 32'(load_err), 32'd0);
    step();
    if (RegWriteW) pulses++;
    chk("timeout.ready_at_64", 32'(ready_m), 32'd1);
    chk("timeout.err_at_64", 32'(load_err), 32'd1);
    step();
    if (RegWriteW) pulses++;
    chk("timeout.no_write", 32'(pulses), 32'd0);
    chk("timeout.ResultW", ResultW, 32'd0);

    // Response on the expiry edge wins over the timeout
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 4'd8, 32'h0, 1'b0, 32'h0);
    step();
    idle_in();
    for (int k = 1; k <= 63; k++) step();
    chk("tie.ready_at_63", 32'(ready_m), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h0BADCAFE);
    step();
    chk("tie.RegWriteW", 32'(RegWriteW), 32'd1);
    chk("tie.WA3W", 32'(WA3W), 32'd8);
    chk("tie.ResultW", ResultW, 32'h0BADCAFE);
    chk("tie.load_err", 32'(load_err), 32'd0);
    idle_in();
    step();
    chk("tie.RegWriteW_after", 32'(RegWriteW), 32'd0);
    chk("tie.ready_after", 32'(ready_m), 32'd1);
    chk("tie.load_err_after", 32'(load_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
